burst_write_arbiter: RTL and testbench

BURST_WRITE_ARBITER -- requirements
Module: burst_write_arbiter

---
 rtl/burst_arb_pkg.sv | 22 ++
 rtl/burst_write_arbiter.sv | 130 +++++++++++++
 tb/tb_burst_write_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_arb_pkg.sv
// Shared state encoding and grant codes for the two-requester burst write arbiter.
package burst_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_IDLE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    function automatic logic [1:0] grant_of(input arb_state_t st);
        case (st)
            ST_OWN0: grant_of = GRANT_S0;
            ST_OWN1: grant_of = GRANT_S1;
            default: grant_of = GRANT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/burst_write_arbiter.sv
// Two-requester Avalon-MM burst write arbiter: round-robin grant, a whole burst
// per grant, one idle bubble between bursts. dbg_state exposes the FSM state.
module burst_write_arbiter
    import burst_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_WIDTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic [ADDRESS_WIDTH-1:0]     s0_address,
    input  logic                         s0_write,
    input  logic [DATA_WIDTH-1:0]        s0_writedata,
    input  logic [BURST_WIDTH-1:0]       s0_burstcount,
    input  logic [BYTE_ENABLE_WIDTH-1:0] s0_byteenable,
    output logic                         s0_waitrequest,

    input  logic [ADDRESS_WIDTH-1:0]     s1_address,
    input  logic                         s1_write,
    input  logic [DATA_WIDTH-1:0]        s1_writedata,
    input  logic [BURST_WIDTH-1:0]       s1_burstcount,
    input  logic [BYTE_ENABLE_WIDTH-1:0] s1_byteenable,
    output logic                         s1_waitrequest,

    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,

    output logic [1:0]                   grant,
    output logic                         burst_err,
    output arb_state_t                   dbg_state
);

    // Handshake: a beat moves when master_write is high and master_waitrequest is
    // low at a rising edge; the owner sees the fabric's waitrequest directly.

    arb_state_t             state, state_next;
    logic                   first_beat;
    logic [BURST_WIDTH-1:0] beats_left;
    logic                   last_owner;

    logic                   owning;
    logic                   accept;
    logic                   final_beat;
    logic                   zero_count;
    logic [BURST_WIDTH-1:0] load_count;
    logic [BURST_WIDTH-1:0] cur_left;
    logic [BURST_WIDTH-1:0] left_next;

    always_comb begin
        state_next        = state;
        master_address    = '0;
        master_write      = 1'b0;
        master_writedata  = '0;
        master_burstcount = '0;
        master_byteenable = '0;
        s0_waitrequest    = 1'b1;
        s1_waitrequest    = 1'b1;

        case (state)
            ST_IDLE: begin
                // last_owner == 1 means s1 was served last, so s0 wins a tie
                if (s0_write && s1_write)
                    state_next = last_owner ? ST_OWN0 : ST_OWN1;
                else if (s0_write)
                    state_next = ST_OWN0;
                else if (s1_write)
                    state_next = ST_OWN1;
            end
            ST_OWN0: begin
                master_address    = s0_address;
                master_write      = s0_write;
                master_writedata  = s0_writedata;
                master_burstcount = s0_burstcount;
                master_byteenable = s0_byteenable;
                s0_waitrequest    = master_waitrequest;
            end
            ST_OWN1: begin
                master_address    = s1_address;
                master_write      = s1_write;
                master_writedata  = s1_writedata;
                master_burstcount = s1_burstcount;
                master_byteenable = s1_byteenable;
                s1_waitrequest    = master_waitrequest;
            end
            default: state_next = ST_IDLE;
        endcase

        owning     = (state == ST_OWN0) || (state == ST_OWN1);
        accept     = master_write && !master_waitrequest;
        zero_count = (master_burstcount == '0);
        load_count = zero_count ? BURST_WIDTH'(1) : master_burstcount;
        // On the grant's first cycle the count is taken live from the owner
        cur_left   = first_beat ? load_count : beats_left;
        left_next  = cur_left - {{(BURST_WIDTH-1){1'b0}}, accept};
        final_beat = owning && accept && (cur_left == BURST_WIDTH'(1));

        if (final_beat)
            state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            first_beat <= 1'b0;
            beats_left <= '0;
            last_owner <= 1'b1;
            burst_err  <= 1'b0;
        end else begin
            state      <= state_next;
            first_beat <= (state == ST_IDLE);
            if (owning)
                beats_left <= left_next;
            if (owning && first_beat && zero_count)
                burst_err <= 1'b1;
            if (final_beat)
                last_owner <= (state == ST_OWN1);
        end
    end

    assign grant     = grant_of(state);
    assign dbg_state = state;

endmodule

// File: tb/tb_burst_write_arbiter.sv
// Directed bench for burst_write_arbiter: ties, backpressure, mid-burst gaps,
// zero burstcount and asynchronous reset, checked against an expected beat queue.
module tb_burst_write_arbiter;
    import burst_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BEW = 4;
    localparam int BW  = 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [AW-1:0]  s_addr [2];
    logic           s_write[2];
    logic [DW-1:0]  s_data [2];
    logic [BW-1:0]  s_bc   [2];
    logic [BEW-1:0] s_be   [2];
    logic           s_wait [2];

    logic [AW-1:0]  master_address;
    logic           master_write;
    logic [DW-1:0]  master_writedata;
    logic [BW-1:0]  master_burstcount;
    logic [BEW-1:0] master_byteenable;
    logic           master_waitrequest;
    logic [1:0]     grant;
    logic           burst_err;
    arb_state_t     dbg_state;

    burst_write_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_ENABLE_WIDTH(BEW), .BURST_WIDTH(BW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s_addr[0]), .s0_write(s_write[0]), .s0_writedata(s_data[0]),
        .s0_burstcount(s_bc[0]), .s0_byteenable(s_be[0]), .s0_waitrequest(s_wait[0]),
        .s1_address(s_addr[1]), .s1_write(s_write[1]), .s1_writedata(s_data[1]),
        .s1_burstcount(s_bc[1]), .s1_byteenable(s_be[1]), .s1_waitrequest(s_wait[1]),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_burstcount(master_burstcount),
        .master_byteenable(master_byteenable), .master_waitrequest(master_waitrequest),
        .grant(grant), .burst_err(burst_err), .dbg_state(dbg_state)
    );

    // scoreboard: {owner, data} of every beat expected at the fabric, in order
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [32:0] exp_q[$];
    int acc_cnt[2];
    int first_acc[2];
    int last_acc[2];
    int req_cyc[2];
    logic bp_on = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            acc_cnt[i] = 0;
            first_acc[i] = 0;
            last_acc[i] = 0;
        end
    endtask

    task automatic expect_burst(input int n, input int beats, input logic [31:0] base);
        for (int i = 0; i < beats; i++)
            exp_q.push_back({n[0], base + 32'(i)});
    endtask

    // monitor: beats accepted at the coming edge, waitrequest routing
    logic [32:0] mon_exp;
    int          mon_o;
    always @(negedge clk) begin
        if (reset_n) begin
            if (master_write && !master_waitrequest) begin
                mon_o = grant[1] ? 1 : 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {grant, master_writedata}, 64'h0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", {grant[1], master_writedata}, mon_exp);
                end
                acc_cnt[mon_o]++;
                if (acc_cnt[mon_o] == 1) first_acc[mon_o] = cyc;
                last_acc[mon_o] = cyc;
            end
            if (grant == GRANT_S0) begin
                check("s0_wait_mirror", s_wait[0], master_waitrequest);
                if (s_write[1]) check("s1_stalled", s_wait[1], 1);
            end else if (grant == GRANT_S1) begin
                check("s1_wait_mirror", s_wait[1], master_waitrequest);
                if (s_write[0]) check("s0_stalled", s_wait[0], 1);
            end
        end
    end

    // driver: one requester's burst; optional write-low gap after gap_after beats
    task automatic drive_burst(input int n, input logic [BW-1:0] bc, input logic [31:0] base,
                               input int gap_after, input int gap_len);
        int beats;
        int sent;
        int budget;
        logic acc;
        beats = (bc == 0) ? 1 : int'(bc);
        sent = 0;
        budget = 0;
        @(posedge clk); #1;
        s_write[n] = 1'b1;
        s_addr[n]  = 32'h1000 * (n + 1);
        s_bc[n]    = bc;
        s_data[n]  = base;
        s_be[n]    = 4'hf;
        req_cyc[n] = cyc;
        while (sent < beats && budget < 200) begin
            @(negedge clk);
            acc = s_write[n] && !s_wait[n];
            @(posedge clk); #1;
            budget++;
            if (acc) begin
                sent++;
                s_data[n] = base + 32'(sent);
                if (sent == gap_after && gap_len > 0) begin
                    s_write[n] = 1'b0;
                    repeat (gap_len) begin
                        @(negedge clk);
                        check("gap_grant", grant, (n == 1) ? GRANT_S1 : GRANT_S0);
                        @(posedge clk); #1;
                    end
                    s_write[n] = 1'b1;
                end
            end
        end
        check("burst_done", sent, beats);
        s_write[n] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_addr[i] = '0; s_write[i] = 1'b0; s_data[i] = '0; s_bc[i] = '0; s_be[i] = '0;
        end
        master_waitrequest = 1'b0;
        clear_stats();

        // reset defaults
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, GRANT_IDLE);
        check("rst_mwrite", master_write, 0);
        check("rst_s0_wait", s_wait[0], 1);
        check("rst_s1_wait", s_wait[1], 1);
        check("rst_err", burst_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", dbg_state, ST_IDLE);
        check("post_rst_maddr", master_address, 0);

        // tie after reset: s0 first, one idle bubble, then s1
        clear_stats();
        expect_burst(0, 4, 32'h20);
        expect_burst(1, 4, 32'h30);
        fork
            drive_burst(0, 4, 32'h20, 0, 0);
            drive_burst(1, 4, 32'h30, 0, 0);
        join
        @(negedge clk);
        check("tie1_latency", first_acc[0] - req_cyc[0], 1);
        check("tie1_bubble", first_acc[1] - last_acc[0], 2);
        check("tie1_beats", {acc_cnt[0][7:0], acc_cnt[1][7:0]}, 16'h0404);

        // next tie: s1 served last, so s0 again
        clear_stats();
        expect_burst(0, 4, 32'h40);
        expect_burst(1, 4, 32'h48);
        fork
            drive_burst(0, 4, 32'h40, 0, 0);
            drive_burst(1, 4, 32'h48, 0, 0);
        join
        check("tie2_s0_first", last_acc[0] < first_acc[1], 1);

        // single requester: 8 beats, data 3..10
        clear_stats();
        expect_burst(0, 8, 32'h3);
        fork
            drive_burst(0, 8, 32'h3, 0, 0);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                check("single_req_grant", grant, GRANT_IDLE);
                @(negedge clk);
                check("single_grant", grant, GRANT_S0);
                check("single_mbc", master_burstcount, 8);
                check("single_maddr", master_address, 32'h1000);
                check("single_mbe", master_byteenable, 4'hf);
            end
        join
        @(negedge clk);
        check("single_beats", acc_cnt[0], 8);
        check("single_latency", first_acc[0] - req_cyc[0], 1);
        check("single_idle", dbg_state, ST_IDLE);
        check("single_idle_grant", grant, GRANT_IDLE);

        // s0 served last: tie now goes to s1
        clear_stats();
        expect_burst(1, 2, 32'h60);
        expect_burst(0, 2, 32'h68);
        fork
            drive_burst(0, 2, 32'h68, 0, 0);
            drive_burst(1, 2, 32'h60, 0, 0);
        join
        check("tie3_s1_first", last_acc[1] < first_acc[0], 1);

        // backpressure on an s1 burst; s0 requests during it and waits
        clear_stats();
        expect_burst(1, 8, 32'h50);
        expect_burst(0, 2, 32'h58);
        bp_on = 1'b1;
        fork
            begin
                drive_burst(1, 8, 32'h50, 0, 0);
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    @(posedge clk); #1;
                    if (bp_on) master_waitrequest = ~master_waitrequest;
                end
                master_waitrequest = 1'b0;
            end
            begin
                @(posedge clk);
                drive_burst(0, 2, 32'h58, 0, 0);
            end
        join
        check("bp_s1_beats", acc_cnt[1], 8);
        check("bp_s0_after", last_acc[1] < first_acc[0], 1);
        check("bp_s1_span", last_acc[1] - first_acc[1] >= 14, 1);

        // owner drops write for 3 cycles after beat 2; s1 stays stalled
        clear_stats();
        expect_burst(0, 4, 32'h90);
        expect_burst(1, 2, 32'hA0);
        fork
            drive_burst(0, 4, 32'h90, 2, 3);
            begin
                repeat (2) @(posedge clk);
                drive_burst(1, 2, 32'hA0, 0, 0);
            end
        join
        check("gap_s0_beats", acc_cnt[0], 4);
        check("gap_s1_after", first_acc[1] - last_acc[0], 2);

        // zero burstcount: one beat, sticky error
        clear_stats();
        check("err_before", burst_err, 0);
        expect_burst(1, 1, 32'h70);
        drive_burst(1, 0, 32'h70, 0, 0);
        @(negedge clk);
        check("zero_beats", acc_cnt[1], 1);
        check("err_set", burst_err, 1);
        expect_burst(0, 2, 32'h78);
        drive_burst(0, 2, 32'h78, 0, 0);
        @(negedge clk);
        check("err_sticky", burst_err, 1);
        check("q_empty_mid", exp_q.size(), 0);

        // asynchronous reset after beat 3 of 8
        clear_stats();
        expect_burst(0, 3, 32'hC0);
        @(posedge clk); #1;
        s_write[0] = 1'b1; s_addr[0] = 32'h1000; s_bc[0] = 4'd8; s_data[0] = 32'hC0; s_be[0] = 4'hf;
        for (int i = 0; i < 50 && acc_cnt[0] < 3; i++) begin
            @(posedge clk); #1;
            if (acc_cnt[0] == 1) s_data[0] = 32'hC1;
            if (acc_cnt[0] == 2) s_data[0] = 32'hC2;
        end
        check("rst_mid_beats", acc_cnt[0], 3);
        check("rst_mid_owning", grant, GRANT_S0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_mwrite", master_write, 0);
        check("rst_mid_grant", grant, GRANT_IDLE);
        check("rst_mid_s0_wait", s_wait[0], 1);
        check("rst_mid_s1_wait", s_wait[1], 1);
        check("rst_mid_err", burst_err, 0);
        s_write[0] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rel_state", dbg_state, ST_IDLE);
        check("q_empty_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
